// File: rtl/sfx_beat_sequencer.sv
// sfx_beat_sequencer: fixed-priority multi-channel beat sequencer for the
// Pong sound path. One effect plays at a time, and its beat index advances
// every TICK_DIV clocks.
// Optional build macro: SFX_QUEUE_EN adds a pending register that holds
// ignored lower-priority triggers until the current sequence completes.
module sfx_beat_sequencer #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CH_W     = 2,
   parameter int unsigned BEAT_W   = 8,
   parameter int unsigned TICK_DIV = 16,
   parameter int unsigned DIV_W    = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS-1:0]        trig,
   input  logic [CHANNELS-1:0]        loop,
   input  logic [CHANNELS*BEAT_W-1:0] len,
   input  logic                       stop,
   output logic [BEAT_W-1:0]          ibeat,
   output logic [CH_W-1:0]            active_ch,
   output logic                       playing,
   output logic                       done
);

   typedef enum logic {S_IDLE, S_PLAY} state_t;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   state_t              r_state, w_state_n;
   logic [DIV_W-1:0]    r_div, w_div_n;
   logic [BEAT_W-1:0]   r_ibeat, w_ibeat_n;
   logic [CH_W-1:0]     r_active, w_active_n;
   logic [BEAT_W-1:0]   r_last, w_last_n;
   logic                r_loop, w_loop_n;
   logic                r_done, w_done_n;

   logic                w_trig_any;
   logic [CH_W-1:0]     w_cand;
   logic                w_tick;
   logic                w_at_last;
   logic                w_start;
   logic [CH_W-1:0]     w_start_ch;

`ifdef SFX_QUEUE_EN
   logic [CHANNELS-1:0] r_pend, w_pend_n;
   logic [CH_W-1:0]     w_pend_ch;

   // Lowest-index pending channel.
   always_comb begin
      logic found;
      found     = 1'b0;
      w_pend_ch = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (r_pend[i] && !found) begin
            w_pend_ch = CH_W'(i);
            found     = 1'b1;
         end
      end
   end
`endif

   // Lowest-index trigger is the start candidate.
   always_comb begin
      w_trig_any = 1'b0;
      w_cand     = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (trig[i] && !w_trig_any) begin
            w_cand     = CH_W'(i);
            w_trig_any = 1'b1;
         end
      end
   end

   // Next-state logic: stop, start/preempt/retrigger, completion, beat stepping.
   always_comb begin
      w_state_n  = r_state;
      w_div_n    = r_div;
      w_ibeat_n  = r_ibeat;
      w_active_n = r_active;
      w_last_n   = r_last;
      w_loop_n   = r_loop;
      w_done_n   = 1'b0;
      w_start    = 1'b0;
      w_start_ch = w_cand;
`ifdef SFX_QUEUE_EN
      w_pend_n   = r_pend;
`endif
      w_tick     = (r_state == S_PLAY) && (r_div == DIV_MAX);
      w_at_last  = (r_ibeat == r_last);

      if (stop) begin
         w_state_n = S_IDLE;
         w_ibeat_n = '0;
         w_div_n   = '0;
`ifdef SFX_QUEUE_EN
         w_pend_n  = '0;
`endif
      end else if (r_state == S_IDLE) begin
         if (w_trig_any) w_start = 1'b1;
      end else begin
         if (w_trig_any && (w_cand <= r_active)) begin
            w_start = 1'b1;
         end else if (w_tick && w_at_last && !r_loop) begin
            // A trigger landing on the completion edge wins over done.
            if (w_trig_any) begin
               w_start = 1'b1;
            end
`ifdef SFX_QUEUE_EN
            else if (|r_pend) begin
               w_start              = 1'b1;
               w_start_ch           = w_pend_ch;
               w_pend_n[w_pend_ch]  = 1'b0;
               w_done_n             = 1'b1;
            end
`endif
            else begin
               w_state_n = S_IDLE;
               w_ibeat_n = '0;
               w_div_n   = '0;
               w_done_n  = 1'b1;
            end
         end else begin
`ifdef SFX_QUEUE_EN
            if (w_trig_any) w_pend_n[w_cand] = 1'b1;
`endif
            if (w_tick) begin
               w_div_n   = '0;
               w_ibeat_n = w_at_last ? '0 : r_ibeat + BEAT_W'(1);
            end else begin
               w_div_n   = r_div + DIV_W'(1);
            end
         end
      end

      if (w_start) begin
         w_state_n  = S_PLAY;
         w_active_n = w_start_ch;
         w_last_n   = len[w_start_ch*BEAT_W +: BEAT_W];
         w_loop_n   = loop[w_start_ch];
         w_ibeat_n  = '0;
         w_div_n    = '0;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_ibeat  <= '0;
         r_active <= '0;
         r_last   <= '0;
         r_loop   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SFX_QUEUE_EN
         r_pend   <= '0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_div    <= w_div_n;
         r_ibeat  <= w_ibeat_n;
         r_active <= w_active_n;
         r_last   <= w_last_n;
         r_loop   <= w_loop_n;
         r_done   <= w_done_n;
`ifdef SFX_QUEUE_EN
         r_pend   <= w_pend_n;
`endif
      end
   end

   assign ibeat     = r_ibeat;
   assign active_ch = r_active;
   assign playing   = (r_state == S_PLAY);
   assign done      = r_done;

endmodule
